cuenta_unos_n: RTL and testbench

Parametrised successor of the 3-bit ones-counter control unit. It counts the ones (or zeros, selected by mode) in a W-bit operand. Work is done bit-serially through an internal shift register under a three-state FSM, with early termination when no ones remain. It sits in the control-unit datapath as a multi-cycle operator: the sequencer pulses `start`, then waits for `fin`.

---
 rtl/cuenta_pkg.sv | 6 +
 rtl/registro_desplazamiento.sv | 20 ++
 rtl/cuenta_unos_n.sv | 54 +++++
 tb/tb_cuenta_unos_n.sv | 91 +++++++++
 4 files changed

// File: rtl/cuenta_pkg.sv
// cuenta_pkg: FSM state encoding and counting-mode constants shared by cuenta_unos_n
package cuenta_pkg;
  typedef enum logic [1:0] {INICIO = 2'b00, CUENTA = 2'b01, FIN = 2'b10} estado_t;
  localparam logic MODO_UNOS = 1'b0;
  localparam logic MODO_CEROS = 1'b1;
endpackage

// File: rtl/registro_desplazamiento.sv
// registro_desplazamiento: W-bit right shifter (clk, clr, load, shift, d in; lsb, resto_cero out)
module registro_desplazamiento #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         lsb,
  output logic         resto_cero
);
  logic [W-1:0] q;
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= q >> 1;
  assign lsb = q[0];
  assign resto_cero = (q >> 1) == '0;
endmodule

// File: rtl/cuenta_unos_n.sv
// cuenta_unos_n: bit-serial ones/zeros counter (clk, start, Valor, modo in; Cuenta, fin, ocupado out)
module cuenta_unos_n
  import cuenta_pkg::*;
#(
  parameter int W = 3,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          start,
  input  logic [W-1:0]  Valor,
  input  logic          modo,
  output logic [CW-1:0] Cuenta,
  output logic          fin,
  output logic          ocupado
);
  localparam int IW = W > 1 ? $clog2(W) : 1;
  estado_t estado;
  logic [IW-1:0] idx;
  logic modo_r, lsb, resto_cero, b, ultimo;
  registro_desplazamiento #(.W(W)) u_sr (
    .clk       (clk),
    .clr       (start),
    .load      (estado == INICIO),
    .shift     (estado == CUENTA),
    .d         (Valor),
    .lsb       (lsb),
    .resto_cero(resto_cero)
  );
  assign b = modo_r == MODO_CEROS ? ~lsb : lsb;
  assign ultimo = (modo_r == MODO_UNOS && resto_cero) || idx == IW'(W - 1);
  always_ff @(posedge clk)
    if (start) begin
      estado <= INICIO;
      Cuenta <= '0;
      fin <= 1'b0;
      ocupado <= 1'b0;
      idx <= '0;
      modo_r <= MODO_UNOS;
    end else if (estado == INICIO) begin
      modo_r <= modo;
      idx <= '0;
      Cuenta <= '0;
      ocupado <= 1'b1;
      estado <= CUENTA;
    end else if (estado == CUENTA) begin
      Cuenta <= Cuenta + CW'(b);
      idx <= idx + 1'b1;
      if (ultimo) begin
        estado <= FIN;
        ocupado <= 1'b0;
        fin <= 1'b1;
      end
    end
endmodule

// File: tb/tb_cuenta_unos_n.sv
// tb_cuenta_unos_n: randomized check of cuenta_unos_n at W=3, 8 and 1 against a popcount model
module tb_cuenta_unos_n;
  logic clk = 1'b0;
  logic start = 1'b1;
  logic modo = 1'b0;
  logic [7:0] valor = '0;
  logic [1:0] c3;
  logic [3:0] c8;
  logic [0:0] c1;
  logic f3, o3, f8, o8, f1, o1;
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  cuenta_unos_n #(.W(3)) u3 (.clk(clk), .start(start), .Valor(valor[2:0]), .modo(modo), .Cuenta(c3), .fin(f3), .ocupado(o3));
  cuenta_unos_n #(.W(8)) u8 (.clk(clk), .start(start), .Valor(valor), .modo(modo), .Cuenta(c8), .fin(f8), .ocupado(o8));
  cuenta_unos_n #(.W(1)) u1 (.clk(clk), .start(start), .Valor(valor[0:0]), .modo(modo), .Cuenta(c1), .fin(f1), .ocupado(o1));
  task automatic check(string tag, int got, int want);
    checks++;
    if (got == want) passed++;
    else $display("FAIL %s got %0d expected %0d", tag, got, want);
  endtask
  function automatic int latencia(int w, bit m, int v);
    int k = 1;
    if (m) return w;
    for (int i = 0; i < w; i++) if (v[i]) k = i + 1;
    return k;
  endfunction
  function automatic int parcial(bit m, int v, int j);
    int n = 0;
    for (int i = 0; i < j; i++) n += int'(v[i] ^ m);
    return n;
  endfunction
  task automatic inst(string tag, int w, int c, int f, int o, int v, bit m, int j);
    int k = latencia(w, m, v);
    int jj = j < k ? j : k;
    if (j < 0) begin
      check({tag, " cuenta rst"}, c, 0);
      check({tag, " fin rst"}, f, 0);
      check({tag, " ocupado rst"}, o, 0);
    end else begin
      check({tag, " cuenta"}, c, parcial(m, v, jj));
      check({tag, " fin"}, f, int'(j >= k));
      check({tag, " ocupado"}, o, int'(j < k));
    end
  endtask
  task automatic todos(string tag, int j, int v, bit m);
    inst($sformatf("%s w3 v=%0h m=%0d j=%0d", tag, v & 7, m, j), 3, int'(c3), int'(f3), int'(o3), v & 7, m, j);
    inst($sformatf("%s w8 v=%0h m=%0d j=%0d", tag, v & 255, m, j), 8, int'(c8), int'(f8), int'(o8), v & 255, m, j);
    inst($sformatf("%s w1 v=%0h m=%0d j=%0d", tag, v & 1, m, j), 1, int'(c1), int'(f1), int'(o1), v & 1, m, j);
  endtask
  task automatic conteo(int v, bit m, int hold);
    start = 1'b1;
    repeat (hold) @(posedge clk);
    #1 todos("reset", -1, v, m);
    valor = 8'(v);
    modo = m;
    start = 1'b0;
    @(posedge clk);
    #1 todos("run", 0, v, m);
    for (int j = 1; j <= 10; j++) begin
      valor = 8'($urandom);
      modo = 1'($urandom);
      @(posedge clk);
      #1 todos("run", j, v, m);
    end
  endtask
  initial begin
    conteo('h05, 1'b0, 2);
    conteo('h01, 1'b0, 1);
    conteo('h00, 1'b0, 1);
    conteo('h00, 1'b1, 1);
    conteo('h07, 1'b1, 1);
    conteo('hFF, 1'b0, 1);
    for (int v = 0; v < 8; v++)
      for (int m = 0; m < 2; m++) conteo(v, 1'(m), 1);
    start = 1'b1;
    @(posedge clk);
    #1 valor = 8'hF0;
    modo = 1'b0;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 todos("abort", -1, 'hF0, 1'b0);
    conteo('h03, 1'b0, 1);
    repeat (40) conteo(int'($urandom_range(0, 255)), 1'($urandom), int'($urandom_range(1, 3)));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
